multicycle_sequencer: RTL and testbench
=======================================

# multicycle_sequencer

Multi-cycle control sequencer for the RISC-V-ISA core. It replaces the single-cycle decode path with an FSM that steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In each state it drives the datapath enables, the mux selects and the instruction/data memory handshakes. It sits between the IR/ALU datapath and the two memory ports, and counts retired instructions.

## Interface
- Clock and reset: one clock; reset is asynchronous and active-low.
- Parameters:
  - CNT_W, default 32: width of the retired-instruction counter.
- Ports:
  - clk  in  1  rising-edge clock
  - rst_n  in  1  asynchronous active-low reset
  - opcode  in  7  IR[6:0]; sampled only in DECODE
  - branch_taken  in  1  branch comparison result from the datapath; valid in EXEC
  - imem_ready  in  1  instruction memory has data this cycle
  - dmem_ready  in  1  data memory access complete this cycle
  - imem_req  out  1  instruction fetch request
  - dmem_req  out  1  data access request
  - dmem_we  out  1  data write (store)
  - ir_we  out  1  load IR from instruction memory
  - pc_we  out  1  update PC
  - pc_src  out  2  00 PC+4, 01 branch target, 10 jump target
  - reg_we  out  1  register file write
  - wb_sel  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate (LUI)
  - alu_src_b  out  1  0 rs2, 1 immediate
  - alu_op  out  2  00 add, 01 compare/sub, 10 R-funct, 11 I-funct
  - imm_sel  out  3  000 I, 001 S, 010 B, 011 U, 100 J
  - illegal  out  1  unsupported opcode trapped (sticky)
  - state  out  3  current state, for debug
  - instret  out  CNT_W  retired-instruction count

## Operation
- State encoding:
  - BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
  - Encoding 7 is unreachable; if entered, the next state is BOOT.
- opc_q: 7-bit register. Captured from opcode in DECODE; holds its value otherwise.
- All outputs except instret and state are a combinational function of state, opc_q and the handshake inputs. Every output is 0 unless listed below.
- Supported opcodes:
  - 0010011 I-ALU
  - 0000011 load
  - 0110011 R-type
  - 1101111 JAL
  - 0100011 store
  - 0110111 LUI
  - 1100011 branch
- BOOT: all outputs 0. Next state is FETCH.
- FETCH:
  - imem_req=1 and held until imem_ready.
  - When imem_ready=1: ir_we=1 for that cycle, next state DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE:
  - Capture opc_q.
  - Supported opcode: next state EXEC. Any other opcode: next state TRAP.
  - imm_sel is driven from the incoming opcode.
- EXEC: imm_sel, alu_src_b and alu_op are driven per opc_q.
  - R-type: alu_src_b=0, alu_op=10.
  - I-ALU: alu_src_b=1, alu_op=11, imm_sel I.
  - Load/store: alu_src_b=1, alu_op=00, imm_sel I or S.
  - LUI: imm_sel U.
  - JAL: imm_sel J.
  - Branch: alu_src_b=0, alu_op=01, imm_sel B, pc_we=1, pc_src=branch_taken?01:00. Next state FETCH.
  - Load/store: next state MEM.
  - R-type, I-ALU, LUI, JAL: next state WB.
- MEM:
  - dmem_req=1; dmem_we=1 for store.
  - Hold until dmem_ready. Address and data stay stable through the wait; the datapath holds the ALU result.
  - Store, on dmem_ready: pc_we=1, pc_src=00, next state FETCH.
  - Load, on dmem_ready: next state WB.
- WB:
  - reg_we=1.
  - wb_sel: load 01, JAL 10, LUI 11, otherwise 00.
  - pc_we=1; pc_src=10 for JAL, otherwise 00.
  - Next state FETCH.
- TRAP: illegal=1, all other outputs 0. Remains in TRAP until reset.
- instret:
  - Increments by 1 on every clock edge where pc_we=1.
  - Wraps modulo 2^CNT_W; no saturation.
- Ready inputs are ignored when the matching request is low.

## Timing
- Reset values while rst_n=0 and in the first cycle after release:
  - state=BOOT.
  - instret=0, opc_q=0, illegal=0.
  - All request, enable and select outputs are 0.
- First imem_req is asserted in the second cycle after rst_n rises.
- Cycles per instruction with zero-wait memories (ready in the first request cycle):
  - branch 3
  - R-type, I-ALU, LUI, JAL, store 4
  - load 5
- Each memory wait cycle adds 1 cycle.
- Reset asserted mid-instruction:
  - All outputs clear immediately (asynchronous).
  - A pending memory request is dropped.
  - There is no partial writeback.
- imem_ready and dmem_ready take effect in the same cycle they are seen. No registered handshake delay.

## Test plan
- Reset release, then add (0110011) with imem_ready=1 → state BOOT→FETCH→DECODE→EXEC→WB; reg_we=1 with wb_sel=00 in WB; instret=1 after 5 edges.
- Load (0000011) with dmem_ready low for 3 cycles → dmem_req held 4 cycles with dmem_we=0; reg_we with wb_sel=01; 8 cycles from FETCH to the next FETCH.
- Branch (1100011) with branch_taken=1, then again with branch_taken=0 → pc_src=01 then 00 in EXEC; no reg_we; 3 cycles each.
- JAL (1101111) → imm_sel=100 in EXEC; in WB reg_we=1, wb_sel=10, pc_src=10.
- Opcode 0000000 → TRAP with illegal=1 sticky; imem_req stays 0 for 20 cycles; rst_n pulse clears it.
- Set instret to 2^CNT_W−1 via a run with CNT_W=4 (15 instructions); the 16th retire wraps instret to 0. Assert rst_n=0 during a MEM wait → dmem_req drops in the same cycle.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with retired-instruction counter
module multicycle_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             reg_we,
  output logic [1:0]       wb_sel,
  output logic             alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_sel,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);
  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd6
  } state_t;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  state_t st, nx;
  logic [6:0] opc_q;
  logic is_i, is_ld, is_r, is_jal, is_st, is_lui, is_br;
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    return op == OP_ST  ? 3'b001 :
           op == OP_BR  ? 3'b010 :
           op == OP_LUI ? 3'b011 :
           op == OP_JAL ? 3'b100 : 3'b000;
  endfunction
  function automatic logic legal(input logic [6:0] op);
    return op == OP_I || op == OP_LD || op == OP_R || op == OP_JAL ||
           op == OP_ST || op == OP_LUI || op == OP_BR;
  endfunction
  assign is_i   = opc_q == OP_I;
  assign is_ld  = opc_q == OP_LD;
  assign is_r   = opc_q == OP_R;
  assign is_jal = opc_q == OP_JAL;
  assign is_st  = opc_q == OP_ST;
  assign is_lui = opc_q == OP_LUI;
  assign is_br  = opc_q == OP_BR;
  assign state  = st;
  // state, latched opcode and retire counter; opcode is only captured in DECODE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st      <= BOOT;
      opc_q   <= '0;
      instret <= '0;
    end else begin
      st      <= nx;
      opc_q   <= st == DECODE ? opcode : opc_q;
      instret <= instret + CNT_W'(pc_we);
    end
  end
  // next state and per-state datapath controls; handshakes act in the cycle they are seen
  always_comb begin
    nx        = st;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'b00;
    reg_we    = 1'b0;
    wb_sel    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    imm_sel   = 3'b000;
    illegal   = 1'b0;
    case (st)
      BOOT: nx = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        ir_we    = imem_ready;
        nx       = imem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        imm_sel = imm_of(opcode);
        nx      = legal(opcode) ? EXEC : TRAP;
      end
      EXEC: begin
        imm_sel   = imm_of(opc_q);
        alu_src_b = is_i | is_ld | is_st;
        alu_op    = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
        pc_we     = is_br;
        pc_src    = {1'b0, is_br & branch_taken};
        nx        = is_br ? FETCH : (is_ld | is_st) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_st;
        pc_we    = is_st & dmem_ready;
        nx       = !dmem_ready ? MEM : is_st ? FETCH : WB;
      end
      WB: begin
        reg_we = 1'b1;
        wb_sel = is_ld ? 2'b01 : is_jal ? 2'b10 : is_lui ? 2'b11 : 2'b00;
        pc_we  = 1'b1;
        pc_src = is_jal ? 2'b10 : 2'b00;
        nx     = FETCH;
      end
      TRAP: illegal = 1'b1;
      default: nx = BOOT;
    endcase
  end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: schedule-based reference model with per-cycle output comparison
module tb_multicycle_sequencer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, alu_src_b, illegal;
  logic [1:0] pc_src, wb_sel, alu_op;
  logic [2:0] imm_sel, state;
  logic [3:0] instret;
  localparam logic [6:0] OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_R = 7'b0110011,
    OP_JAL = 7'b1101111, OP_ST = 7'b0100011, OP_LUI = 7'b0110111, OP_BR = 7'b1100011;
  localparam int K_ILL = 0, K_I = 1, K_LD = 2, K_R = 3, K_JAL = 4, K_ST = 5, K_LUI = 6, K_BR = 7;
  always #5 clk = ~clk;
  multicycle_sequencer #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .reg_we(reg_we), .wb_sel(wb_sel), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .imm_sel(imm_sel), .illegal(illegal), .state(state),
    .instret(instret)
  );
  logic [19:0] act;
  assign act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, reg_we, wb_sel,
                alu_src_b, alu_op, imm_sel, illegal, state};
  typedef struct packed {
    logic rst;
    logic [6:0] op;
    logic bt, ir, dr;
    logic [19:0] exp;
    logic [3:0] cnt;
  } rec_t;
  rec_t q[$];
  rec_t cur;
  bit cur_valid = 0;
  int errors = 0, checks = 0, ret = 0;
  int dmem_cnt = 0, irwe_cnt = 0, regwe_cnt = 0;
  function automatic logic [19:0] mk(input logic ireq, dreq, dwe, irwe, pcwe,
      input logic [1:0] psrc, input logic rwe, input logic [1:0] wsel, input logic asb,
      input logic [1:0] aop, input logic [2:0] imm, input logic ill, input logic [2:0] st);
    return {ireq, dreq, dwe, irwe, pcwe, psrc, rwe, wsel, asb, aop, imm, ill, st};
  endfunction
  function automatic int kind(input logic [6:0] op);
    case (op)
      OP_I: return K_I;
      OP_LD: return K_LD;
      OP_R: return K_R;
      OP_JAL: return K_JAL;
      OP_ST: return K_ST;
      OP_LUI: return K_LUI;
      OP_BR: return K_BR;
      default: return K_ILL;
    endcase
  endfunction
  function automatic logic [2:0] imm_for(input int k);
    return k == K_ST ? 3'd1 : k == K_BR ? 3'd2 : k == K_LUI ? 3'd3 : k == K_JAL ? 3'd4 : 3'd0;
  endfunction
  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic push(input logic rst, input logic [6:0] op, input logic bt, ir, dr,
                      input logic [19:0] e);
    rec_t r;
    r.rst = rst; r.op = op; r.bt = bt; r.ir = ir; r.dr = dr; r.exp = e;
    if (rst) ret = 0;
    r.cnt = 4'(ret);
    ret += int'(e[15]);
    q.push_back(r);
  endtask
  task automatic boot();
    push(0, rop(), rb(), rb(), rb(), '0);
  endtask
  task automatic rst_cycle();
    push(1, rop(), rb(), rb(), rb(), '0);
  endtask
  task automatic instr(input logic [6:0] op, input int iw, dw, btm, input bit abort);
    int k;
    logic bt;
    logic asb;
    logic [1:0] aop, wsel;
    k = kind(op);
    repeat (iw) push(0, rop(), rb(), 0, rb(), mk(1,0,0,0,0,0,0,0,0,0,0,0,3'd1));
    push(0, rop(), rb(), 1, rb(), mk(1,0,0,1,0,0,0,0,0,0,0,0,3'd1));
    push(0, op, rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,imm_for(k),0,3'd2));
    if (k == K_ILL) begin
      repeat (20) push(0, rop(), rb(), rb(), rb(), mk(0,0,0,0,0,0,0,0,0,0,0,1,3'd6));
      return;
    end
    bt = btm == 2 ? rb() : 1'(btm);
    asb = k == K_I || k == K_LD || k == K_ST;
    aop = k == K_R ? 2'b10 : k == K_I ? 2'b11 : k == K_BR ? 2'b01 : 2'b00;
    push(0, rop(), bt, rb(), rb(), mk(0,0,0,0, k == K_BR, k == K_BR ? {1'b0, bt} : 2'b00,
         0, 0, asb, aop, imm_for(k), 0, 3'd3));
    if (k == K_BR) return;
    if (k == K_LD || k == K_ST) begin
      repeat (dw) push(0, rop(), rb(), rb(), 0, mk(0,1,k == K_ST,0,0,0,0,0,0,0,0,0,3'd4));
      if (abort) begin
        rst_cycle();
        boot();
        return;
      end
      push(0, rop(), rb(), rb(), 1, mk(0,1,k == K_ST,0,k == K_ST,0,0,0,0,0,0,0,3'd4));
      if (k == K_ST) return;
    end
    wsel = k == K_LD ? 2'b01 : k == K_JAL ? 2'b10 : k == K_LUI ? 2'b11 : 2'b00;
    push(0, rop(), rb(), rb(), rb(), mk(0,0,0,0,1, k == K_JAL ? 2'b10 : 2'b00, 1, wsel,
         0,0,0,0,3'd5));
  endtask
  task automatic run();
    while (q.size() > 0) begin
      @(negedge clk);
      cur = q.pop_front();
      rst_n = !cur.rst;
      opcode = cur.op;
      branch_taken = cur.bt;
      imem_ready = cur.ir;
      dmem_ready = cur.dr;
      cur_valid = 1;
    end
    @(negedge clk);
    cur_valid = 0;
    rst_n = 1;
    imem_ready = 0;
    dmem_ready = 0;
    #2;
  endtask
  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask
  always @(negedge clk) begin
    #2;
    if (cur_valid) begin
      checks++;
      if (act !== cur.exp || instret !== cur.cnt) begin
        errors++;
        $display("FAIL cycle t=%0t: outputs got %b expected %b, instret got %0d expected %0d",
                 $time, act, cur.exp, instret, cur.cnt);
      end
      dmem_cnt += int'(dmem_req);
      irwe_cnt += int'(ir_we);
      regwe_cnt += int'(reg_we);
    end
  end
  initial begin
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outputs", int'(act), 0);
    chk("reset_instret", int'(instret), 0);
    boot();
    instr(OP_R, 0, 0, 2, 0);
    instr(OP_LD, 0, 3, 2, 0);
    instr(OP_BR, 0, 0, 1, 0);
    instr(OP_BR, 0, 0, 0, 0);
    instr(OP_JAL, 0, 0, 2, 0);
    run();
    chk("directed_instret", int'(instret), 5);
    chk("load_dmem_req_cycles", dmem_cnt, 4);
    chk("ir_we_count", irwe_cnt, 5);
    chk("reg_we_count", regwe_cnt, 3);
    repeat (11) instr(OP_I, $urandom_range(0, 2), 0, 2, 0);
    run();
    chk("instret_wrap", int'(instret), 0);
    for (int n = 0; n < 60; n++) begin
      logic [6:0] op;
      case ($urandom_range(0, 6))
        0: op = OP_I;
        1: op = OP_LD;
        2: op = OP_R;
        3: op = OP_JAL;
        4: op = OP_ST;
        5: op = OP_LUI;
        default: op = OP_BR;
      endcase
      instr(op, $urandom_range(0, 3), $urandom_range(0, 3), 2,
            (op == OP_LD || op == OP_ST) && $urandom_range(0, 7) == 0);
    end
    run();
    instr(7'b0000000, 1, 0, 2, 0);
    run();
    chk("trap_illegal_sticky", int'(illegal), 1);
    chk("trap_no_fetch", int'(imem_req), 0);
    chk("trap_state", int'(state), 6);
    rst_cycle();
    boot();
    instr(OP_R, 0, 0, 2, 0);
    run();
    chk("illegal_cleared", int'(illegal), 0);
    chk("instret_after_reset", int'(instret), 1);
    boot();
    q.delete();
    ret = 0;
    instr(OP_ST, 0, 5, 2, 0);
    q.delete();
    ret = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
